// File: rtl/vec_alu_sequencer_if.sv
// Sequencer bus: decoder instruction fields, RF read/write ports, ALU operand/result path, status.
// master = sequencer side (drives RF addresses, ALU operands, writeback, status);
// slave  = decoder/RF/ALU side (drives instruction fields, read data, ALU result).
interface vec_alu_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int REG_W  = 2,
    parameter int ELEM_W = 3
);
    logic                    start;
    logic [3:0]              opcode;
    logic [ELEM_W:0]         vec_len;
    logic [REG_W-1:0]        src_a;
    logic [REG_W-1:0]        src_b;
    logic [REG_W-1:0]        dst;
    logic [DATA_W-1:0]       scalar;
    logic [REG_W+ELEM_W-1:0] rd_addr_a;
    logic [REG_W+ELEM_W-1:0] rd_addr_b;
    logic [DATA_W-1:0]       rd_data_a;
    logic [DATA_W-1:0]       rd_data_b;
    logic [3:0]              alu_op;
    logic [DATA_W-1:0]       alu_a;
    logic [DATA_W-1:0]       alu_b;
    logic [DATA_W-1:0]       alu_result;
    logic                    wr_en;
    logic [REG_W+ELEM_W-1:0] wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    busy;
    logic                    done;
    logic                    illegal_op;

    modport master (
        input  start, opcode, vec_len, src_a, src_b, dst, scalar,
               rd_data_a, rd_data_b, alu_result,
        output rd_addr_a, rd_addr_b, alu_op, alu_a, alu_b,
               wr_en, wr_addr, wr_data, busy, done, illegal_op
    );

    modport slave (
        output start, opcode, vec_len, src_a, src_b, dst, scalar,
               rd_data_a, rd_data_b, alu_result,
        input  rd_addr_a, rd_addr_b, alu_op, alu_a, alu_b,
               wr_en, wr_addr, wr_data, busy, done, illegal_op
    );
endinterface

// File: rtl/vec_alu_sequencer.sv
// Sequences one vector instruction through the element ALU, one element per cycle.
// Latency: element k read in cycle 1+k, written in 2+k; done in cycle len+2 (cycle 2 if empty/illegal).
// Backpressure: none; start is accepted only in IDLE or FIN and ignored while busy.
// Ports: clk, reset_n (async active-low), bus (master side of vec_alu_sequencer_if).
module vec_alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int REG_W  = 2,
    parameter int ELEM_W = 3
) (
    input  logic clk,
    input  logic reset_n,
    vec_alu_sequencer_if.master bus
);
    localparam int              VLEN   = 1 << ELEM_W;
    localparam logic [ELEM_W:0] VLEN_L = (ELEM_W+1)'(VLEN);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t              state;
    logic [3:0]          op_q;
    logic [REG_W-1:0]    src_a_q;
    logic [REG_W-1:0]    src_b_q;
    logic [REG_W-1:0]    dst_q;
    logic [DATA_W-1:0]   scalar_q;
    logic [ELEM_W:0]     len_q;
    logic [ELEM_W-1:0]   idx;
    logic [ELEM_W-1:0]   pipe_idx;
    logic                pipe_valid;
    logic                busy_q;
    logic                done_q;
    logic                illegal_q;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1111: op_legal = 1'b1;
            default:                                     op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_vv(input logic [3:0] op);
        op_is_vv = (op == 4'b0001) || (op == 4'b0010);
    endfunction

    logic [ELEM_W:0] len_in;
    logic            accept;
    logic            last_elem;

    assign len_in    = (bus.vec_len > VLEN_L) ? VLEN_L : bus.vec_len;
    assign accept    = bus.start && ((state == IDLE) || (state == FIN));
    // Compare in ELEM_W+1 bits so len==VLEN terminates at idx==VLEN-1 instead of wrapping.
    assign last_elem = ({1'b0, idx} == (len_q - (ELEM_W+1)'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op_q       <= '0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            dst_q      <= '0;
            scalar_q   <= '0;
            len_q      <= '0;
            idx        <= '0;
            pipe_idx   <= '0;
            pipe_valid <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            // One-stage pipe: the element read this cycle is written back next cycle.
            pipe_valid <= (state == RUN);
            pipe_idx   <= idx;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (accept) begin
                        op_q     <= bus.opcode;
                        src_a_q  <= bus.src_a;
                        src_b_q  <= bus.src_b;
                        dst_q    <= bus.dst;
                        scalar_q <= bus.scalar;
                        len_q    <= len_in;
                        idx      <= '0;
                        busy_q   <= 1'b1;
                        // Empty or illegal instructions spend one busy cycle in DRAIN
                        // (no writes) so done still lands two cycles after start.
                        if ((len_in == '0) || !op_legal(bus.opcode))
                            state <= DRAIN;
                        else
                            state <= RUN;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    if (last_elem)
                        state <= DRAIN;
                    else
                        idx <= idx + ELEM_W'(1);
                end
                DRAIN: begin
                    state     <= FIN;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    illegal_q <= !op_legal(op_q);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_addr_a  = {src_a_q, idx};
    assign bus.rd_addr_b  = {src_b_q, idx};
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = bus.rd_data_a;
    assign bus.alu_b      = op_is_vv(op_q) ? bus.rd_data_b : scalar_q;
    assign bus.wr_en      = pipe_valid;
    assign bus.wr_addr    = {dst_q, pipe_idx};
    assign bus.wr_data    = bus.alu_result;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Bench for vec_alu_sequencer: bench-side register file and ALU, cycle-indexed expectation tables.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_vec_alu_sequencer;
    localparam int MAXC = 4096;
    localparam bit [15:0] LEGAL_MASK = 16'b1000_1111_1110_0110;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vec_alu_sequencer_if #(.DATA_W(8), .REG_W(2), .ELEM_W(3)) bus();

    vec_alu_sequencer #(.DATA_W(8), .REG_W(2), .ELEM_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- environment: ALU + register file ----------------
    function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] t;
        t = {a, a};
        case (op)
            4'b0001, 4'b0101, 4'b1111: return a + b;
            4'b0010, 4'b0110, 4'b1011: return a - b;
            4'b0111: return a & b;
            4'b1000: begin t = t << b[2:0]; return t[15:8]; end
            4'b1001: begin t = t >> b[2:0]; return t[7:0]; end
            4'b1010: return a ^ b;
            default: return a | b;
        endcase
    endfunction

    logic [7:0] rf  [32];
    logic [7:0] img [32];
    logic       ld_all = 1'b0;

    always @(posedge clk) begin
        bus.rd_data_a <= rf[bus.rd_addr_a];
        bus.rd_data_b <= rf[bus.rd_addr_b];
        if (ld_all) begin
            for (int i = 0; i < 32; i++) rf[i] <= img[i];
        end else if (bus.wr_en) begin
            rf[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.alu_result = alu(bus.alu_op, bus.alu_a, bus.alu_b);

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_on = 1'b0;
    int done_seen = -1;
    int ill_seen = -1;
    int wr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         exp_wr   [MAXC];
    bit [4:0]   exp_wa   [MAXC];
    bit [7:0]   exp_wd   [MAXC];
    bit         exp_rd   [MAXC];
    bit [4:0]   exp_ra   [MAXC];
    bit [4:0]   exp_rb   [MAXC];
    bit         exp_busy [MAXC];
    bit         exp_done [MAXC];
    bit         exp_ill  [MAXC];
    logic [7:0] mrf [32];
    int         free_cyc = 0;
    int         last_t0, last_dst, last_n;
    logic [7:0] last_snap [8];

    // Apply an instruction started in cycle c; a start before the previous done cycle is dropped.
    task automatic model_start(input int c, input logic [3:0] op, input int len_raw,
                               input int sa, input int sb, input int d, input logic [7:0] sc);
        int n;
        int dn;
        bit legal;
        logic [7:0] res [8];
        if (c < free_cyc) return;
        legal = LEGAL_MASK[op];
        n = (len_raw > 8) ? 8 : len_raw;
        if (!legal) n = 0;
        for (int k = 0; k < n; k++)
            res[k] = alu(op, mrf[sa*8+k], (op == 4'b0001 || op == 4'b0010) ? mrf[sb*8+k] : sc);
        last_t0 = c; last_dst = d; last_n = n;
        for (int k = 0; k < 8; k++) last_snap[k] = mrf[d*8+k];
        for (int k = 0; k < n; k++) begin
            exp_rd[c+1+k] = 1'b1;
            exp_ra[c+1+k] = 5'(sa*8+k);
            exp_rb[c+1+k] = 5'(sb*8+k);
            exp_wr[c+2+k] = 1'b1;
            exp_wa[c+2+k] = 5'(d*8+k);
            exp_wd[c+2+k] = res[k];
            mrf[d*8+k] = res[k];
        end
        dn = (n > 0) ? c + n + 2 : c + 2;
        for (int t = c + 1; t < dn; t++) exp_busy[t] = 1'b1;
        exp_done[dn] = 1'b1;
        exp_ill[dn] = !legal;
        free_cyc = dn;
    endtask

    // Reset in cycle r: nothing from r onward happens; writes scheduled at/after r never land.
    task automatic model_abort(input int r);
        for (int t = r; t < MAXC; t++) begin
            exp_wr[t] = 0; exp_rd[t] = 0; exp_busy[t] = 0; exp_done[t] = 0; exp_ill[t] = 0;
        end
        for (int k = 0; k < last_n; k++)
            if (last_t0 + 2 + k >= r) mrf[last_dst*8+k] = last_snap[k];
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on && cyc < MAXC) begin
            check("wr_en", 32'(bus.wr_en), 32'(exp_wr[cyc]));
            if (exp_wr[cyc]) begin
                check("wr_addr", 32'(bus.wr_addr), 32'(exp_wa[cyc]));
                check("wr_data", 32'(bus.wr_data), 32'(exp_wd[cyc]));
            end
            if (exp_rd[cyc]) begin
                check("rd_addr_a", 32'(bus.rd_addr_a), 32'(exp_ra[cyc]));
                check("rd_addr_b", 32'(bus.rd_addr_b), 32'(exp_rb[cyc]));
            end
            check("busy", 32'(bus.busy), 32'(exp_busy[cyc]));
            check("done", 32'(bus.done), 32'(exp_done[cyc]));
            check("illegal_op", 32'(bus.illegal_op), 32'(exp_ill[cyc]));
            if (bus.done === 1'b1) done_seen = cyc;
            if (bus.illegal_op === 1'b1) ill_seen = cyc;
            if (bus.wr_en === 1'b1) wr_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [3:0] op, input int len, input int sa, input int sb,
                         input int d, input logic [7:0] sc);
        bus.start = 1'b1; bus.opcode = op; bus.vec_len = 4'(len);
        bus.src_a = 2'(sa); bus.src_b = 2'(sb); bus.dst = 2'(d); bus.scalar = sc;
        model_start(cyc, op, len, sa, sb, d, sc);
        tick();
        // Scramble the fields so a sequencer that fails to latch them is exposed.
        bus.start = 1'b0; bus.opcode = 4'($urandom); bus.vec_len = 4'($urandom);
        bus.src_a = 2'($urandom); bus.src_b = 2'($urandom); bus.dst = 2'($urandom);
        bus.scalar = 8'($urandom);
    endtask

    task automatic load_img();
        ld_all = 1'b1;
        tick();
        ld_all = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = img[i];
    endtask

    logic [3:0] legal_tab [10] = '{4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111,
                                   4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1111};

    initial begin
        int t0;
        int w0;
        logic [3:0] op;
        bus.start = 1'b0; bus.opcode = '0; bus.vec_len = '0; bus.src_a = '0;
        bus.src_b = '0; bus.dst = '0; bus.scalar = '0;
        for (int i = 0; i < 32; i++) begin img[i] = '0; rf[i] = '0; end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_illegal", 32'(bus.illegal_op), 0);
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_rd_addr_a", 32'(bus.rd_addr_a), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_alu_op", 32'(bus.alu_op), 0);
        reset_n = 1'b1;
        free_cyc = cyc;
        chk_on = 1'b1;
        tick();

        // VV add: V0=[1..8], V1=[10..80] -> V2
        for (int k = 0; k < 8; k++) begin img[k] = 8'(k + 1); img[8+k] = 8'(10 * (k + 1)); end
        load_img();
        w0 = wr_cnt; t0 = cyc;
        issue(4'b0001, 8, 0, 1, 2, 8'h00);
        repeat (12) tick();
        for (int k = 0; k < 8; k++) check("vv_add_dst", 32'(rf[16+k]), 32'(11 * (k + 1)));
        check("vv_add_done_cycle", 32'(done_seen), 32'(t0 + 10));
        check("vv_add_writes", 32'(wr_cnt - w0), 8);

        // VS rotate-left: V3[0]=0x81, scalar 1 -> V2[0]=0x03
        img[24] = 8'h81;
        load_img();
        issue(4'b1000, 1, 3, 0, 2, 8'h01);
        check("rol_alu_b_read", 32'(bus.alu_b), 1);
        tick();
        check("rol_alu_b_write", 32'(bus.alu_b), 1);
        check("rol_wr_data", 32'(bus.wr_data), 32'h03);
        repeat (3) tick();
        check("rol_dst", 32'(rf[16]), 32'h03);

        // In-place subtract: V1 = V1 - 3
        for (int k = 0; k < 8; k++) img[8+k] = 8'd5;
        load_img();
        issue(4'b1011, 8, 1, 0, 1, 8'd3);
        repeat (11) tick();
        for (int k = 0; k < 8; k++) check("inplace_dst", 32'(rf[8+k]), 2);

        // len 0 and illegal opcode: no writes, done at cycle 2
        w0 = wr_cnt; ill_seen = -1; t0 = cyc;
        issue(4'b0001, 0, 0, 1, 3, 8'h00);
        repeat (3) tick();
        check("len0_done_cycle", 32'(done_seen), 32'(t0 + 2));
        check("len0_not_illegal", 32'(ill_seen), 32'hFFFF_FFFF);
        t0 = cyc;
        issue(4'b0011, 4, 0, 1, 3, 8'h00);
        repeat (3) tick();
        check("illegal_done_cycle", 32'(done_seen), 32'(t0 + 2));
        check("illegal_flag_cycle", 32'(ill_seen), 32'(t0 + 2));
        check("empty_no_writes", 32'(wr_cnt - w0), 0);

        // len 12 clamps to 8; a second start during RUN is ignored
        w0 = wr_cnt;
        issue(4'b0101, 12, 0, 0, 3, 8'd7);
        tick();
        issue(4'b0010, 3, 1, 1, 0, 8'd0);
        repeat (10) tick();
        check("clamp_writes", 32'(wr_cnt - w0), 8);
        for (int k = 0; k < 8; k++) check("clamp_dst", 32'(rf[24+k]), 32'(k + 8));

        // Reset in cycle 4 of a len-8 op
        t0 = cyc;
        issue(4'b0101, 8, 0, 0, 1, 8'd1);
        repeat (3) tick();
        check("abort_pre_wr_en", 32'(bus.wr_en), 1);
        done_seen = -1;
        reset_n = 1'b0;
        model_abort(cyc);
        #1;
        check("abort_wr_en", 32'(bus.wr_en), 0);
        check("abort_busy", 32'(bus.busy), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        free_cyc = cyc;
        repeat (12) tick();
        check("abort_no_done", 32'(done_seen), 32'hFFFF_FFFF);
        issue(4'b0001, 8, 0, 3, 2, 8'h00);
        repeat (11) tick();

        // Randomized instruction stream, including starts while busy
        for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
        load_img();
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal_tab[$urandom_range(0, 9)];
                issue(op, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), 8'($urandom));
            end else begin
                tick();
            end
        end
        repeat (15) tick();
        for (int i = 0; i < 32; i++) check("final_rf", 32'(rf[i]), 32'(mrf[i]));

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
